// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types for the two-requester memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam owner_e RR_RESET_LAST = OWN_D;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : Two-way grant selector with last-granted pointer.
//            Define MEM_ARB_RR_EN for round-robin, otherwise data wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en_i,
    input  logic   if_req_i,
    input  logic   d_req_i,
    output logic   if_gnt_o,
    output logic   d_gnt_o,
    output owner_e owner_o
);

    owner_e last_q;
    owner_e last_d;
    logic   prefer_if;
    logic   d_wins;

`ifdef MEM_ARB_RR_EN
    assign prefer_if = (last_q == OWN_D);
`else
    logic unused_last;
    assign prefer_if   = 1'b0;
    assign unused_last = (last_q == OWN_D);
`endif

    // Data takes the slot unless fetch also asks and the policy favours fetch.
    assign d_wins   = d_req_i && !(if_req_i && prefer_if);
    assign d_gnt_o  = en_i && d_wins;
    assign if_gnt_o = en_i && if_req_i && !d_wins;
    assign owner_o  = d_gnt_o ? OWN_D : OWN_IF;

    always_comb begin
        last_d = last_q;
        if (d_gnt_o) begin
            last_d = OWN_D;
        end else if (if_gnt_o) begin
            last_d = OWN_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= RR_RESET_LAST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule : mem_arb_pick

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates fetch and data ports onto one memory, 2-cycle latency.
//            Policy macro: MEM_ARB_RR_EN (round-robin when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    state_e            state_q, state_d;
    owner_e            owner_q, pick_owner;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              we_q;
    logic              if_rvalid_q, d_rvalid_q;
    logic [DWIDTH-1:0] if_rdata_q, d_rdata_q;
    logic              pick_en, any_gnt, in_access;

    assign pick_en   = (state_q == IDLE) && !rst;
    assign any_gnt   = if_gnt_o || d_gnt_o;
    assign in_access = (state_q == ACCESS) && !rst;

    mem_arb_pick u_pick (
        .clk      (clk),
        .rst      (rst),
        .en_i     (pick_en),
        .if_req_i (if_req_i),
        .d_req_i  (d_req_i),
        .if_gnt_o (if_gnt_o),
        .d_gnt_o  (d_gnt_o),
        .owner_o  (pick_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_gnt) state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if (any_gnt) begin
                owner_q <= pick_owner;
                if (d_gnt_o) begin
                    addr_q  <= d_addr_i;
                    we_q    <= d_we_i;
                    wdata_q <= d_wdata_i;
                end else begin
                    addr_q  <= if_addr_i;
                    we_q    <= 1'b0;
                end
            end
            if (state_q == ACCESS) begin
                if (owner_q == OWN_IF) begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= mem_data_i;
                end else begin
                    d_rvalid_q <= 1'b1;
                    d_rdata_q  <= we_q ? '0 : mem_data_i;
                end
            end
        end
    end

    // Enables are masked by rst so an aborted store never reaches memory.
    assign mem_read_en_o  = in_access && !we_q;
    assign mem_write_en_o = in_access && we_q;
    assign mem_addr_o     = addr_q;
    assign mem_data_o     = wdata_q;
    assign if_rvalid_o    = if_rvalid_q;
    assign if_rdata_o     = if_rdata_q;
    assign d_rvalid_o     = d_rvalid_q;
    assign d_rdata_o      = d_rdata_q;

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed scoreboard bench for mem_arbiter (default fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i, d_req_i, d_we_i;
    logic [AW-1:0] if_addr_i, d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
    logic [DW-1:0] if_rdata_o, d_rdata_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o, mem_data_i;
    logic          mem_read_en_o, mem_write_en_o;

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_gnt_o       (if_gnt_o),
        .if_rvalid_o    (if_rvalid_o),
        .if_rdata_o     (if_rdata_o),
        .d_req_i        (d_req_i),
        .d_we_i         (d_we_i),
        .d_addr_i       (d_addr_i),
        .d_wdata_i      (d_wdata_i),
        .d_gnt_o        (d_gnt_o),
        .d_rvalid_o     (d_rvalid_o),
        .d_rdata_o      (d_rdata_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_read_en_o  (mem_read_en_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_data_i     (mem_data_i)
    );

    // 64-word memory at 0x01000000; anything else reads 0xDEADBEEF.
    logic [31:0] mem [0:63];
    logic        in_range;
    assign in_range   = (mem_addr_o[31:8] == 24'h010000);
    assign mem_data_i = in_range ? mem[mem_addr_o[7:2]] : 32'hDEADBEEF;
    always @(posedge clk) if (mem_write_en_o && in_range) mem[mem_addr_o[7:2]] <= mem_data_o;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t if_q[$];
    exp_t d_q[$];

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every response and polices grant spacing.
    logic gnt_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            gnt_prev = 1'b0;
        end else begin
            if (gnt_prev) check("gnt_in_access", {31'b0, if_gnt_o | d_gnt_o}, 32'h0);
            gnt_prev = if_gnt_o | d_gnt_o;
            if (if_rvalid_o) begin
                if (if_q.size() == 0) begin
                    check("if_unexpected_rvalid", 32'h1, 32'h0);
                end else begin
                    e = if_q.pop_front();
                    check("if_rdata", if_rdata_o, e.data);
                    check("if_latency", cyc, e.cyc);
                end
            end
            if (d_rvalid_o) begin
                if (d_q.size() == 0) begin
                    check("d_unexpected_rvalid", 32'h1, 32'h0);
                end else begin
                    e = d_q.pop_front();
                    check("d_rdata", d_rdata_o, e.data);
                    check("d_latency", cyc, e.cyc);
                end
            end
        end
    end

    task automatic do_req(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data);
        bit   got = 0;
        exp_t e;
        @(posedge clk); #1;
        if (is_d) begin
            d_req_i = 1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata;
        end else begin
            if_req_i = 1; if_addr_i = addr;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_d ? d_gnt_o : if_gnt_o) begin
                check("other_gnt_low", {31'b0, is_d ? if_gnt_o : d_gnt_o}, 32'h0);
                e.data = exp_data;
                e.cyc  = cyc + 2;
                if (is_d) d_q.push_back(e); else if_q.push_back(e);
                got = 1;
                break;
            end
        end
        if (!got) check("gnt_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        if_req_i = 0; d_req_i = 0; d_we_i = 0;
        @(negedge clk);
        check("access_addr", mem_addr_o, addr);
        check("access_rd_en", {31'b0, mem_read_en_o}, {31'b0, ~we});
        check("access_wr_en", {31'b0, mem_write_en_o}, {31'b0, we});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int dg, ig;
        exp_t e;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h00500093;
        mem[4] = 32'h0;
        mem[8] = 32'h0BADF00D;

        // Reset with both requests high: no grants may appear.
        rst = 1; if_req_i = 1; d_req_i = 1; d_we_i = 0;
        if_addr_i = 32'h0100_0000; d_addr_i = 32'h0100_0004; d_wdata_i = 32'h0;
        @(negedge clk);
        check("rst_if_gnt", {31'b0, if_gnt_o}, 32'h0);
        check("rst_d_gnt", {31'b0, d_gnt_o}, 32'h0);
        @(posedge clk); #1;
        if_req_i = 0; d_req_i = 0;
        @(negedge clk);
        check("rst_rvalids", {30'b0, if_rvalid_o, d_rvalid_o}, 32'h0);
        check("rst_if_rdata", if_rdata_o, 32'h0);
        check("rst_d_rdata", d_rdata_o, 32'h0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_data", mem_data_o, 32'h0);
        check("rst_mem_en", {30'b0, mem_read_en_o, mem_write_en_o}, 32'h0);
        @(posedge clk); #1;
        rst = 0;

        do_req(0, 0, 32'h0100_0000, 32'h0, 32'h00500093);
        // A fetch with d_we_i high is still a read.
        d_we_i = 1;
        do_req(0, 0, 32'h0100_0000, 32'h0, 32'h00500093);
        do_req(1, 1, 32'h0100_0010, 32'hCAFEF00D, 32'h0);
        do_req(1, 0, 32'h0100_0010, 32'h0, 32'hCAFEF00D);
        idle(2);
        check("if_rdata_held", if_rdata_o, 32'h00500093);
        do_req(0, 0, 32'h0000_0000, 32'h0, 32'hDEADBEEF);

        // Contention for 6 cycles: fixed priority gives data every slot.
        idle(2);
        if_req_i = 1; if_addr_i = 32'h0100_0000;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h0100_0010;
        dg = 0; ig = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (d_gnt_o) begin
                if (dg > 0) check("b2b_rvalid_with_gnt", {31'b0, d_rvalid_o}, 32'h1);
                e.data = 32'hCAFEF00D;
                e.cyc  = cyc + 2;
                d_q.push_back(e);
                dg++;
            end
            if (if_gnt_o) ig++;
        end
        @(posedge clk); #1;
        if_req_i = 0; d_req_i = 0;
        check("contention_d_gnts", dg, 32'd3);
        check("contention_if_gnts", ig, 32'd0);

        // Reset in the ACCESS cycle of a store aborts it completely.
        idle(3);
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h0100_0020; d_wdata_i = 32'h12345678;
        @(negedge clk);
        check("abort_store_gnt", {31'b0, d_gnt_o}, 32'h1);
        @(posedge clk); #1;
        rst = 1; d_req_i = 0; d_we_i = 0; if_req_i = 1;
        @(negedge clk);
        check("abort_no_write_en", {31'b0, mem_write_en_o}, 32'h0);
        check("rst_blocks_gnt", {31'b0, if_gnt_o}, 32'h0);
        @(posedge clk); #1;
        rst = 0; if_req_i = 0;
        @(negedge clk);
        check("abort_no_rvalid", {30'b0, if_rvalid_o, d_rvalid_o}, 32'h0);
        @(negedge clk);
        check("abort_no_rvalid2", {30'b0, if_rvalid_o, d_rvalid_o}, 32'h0);
        check("abort_mem_intact", mem[8], 32'h0BADF00D);
        do_req(1, 0, 32'h0100_0020, 32'h0, 32'h0BADF00D);

        for (int i = 0; i < 10 && (if_q.size() + d_q.size()) > 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", if_q.size() + d_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_mem_arbiter

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width.
REQ-002 SHALL have parameter DWIDTH, default 32, data width.
REQ-003 SHALL have port clk  in  1  single clock; one clock domain only.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port if_req_i  in  1  fetch request.
REQ-006 SHALL have port if_addr_i  in  AWIDTH  fetch byte address.
REQ-007 SHALL have port if_gnt_o  out  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_rvalid_o  out  1  fetch response valid, 1-cycle pulse.
REQ-009 SHALL have port if_rdata_o  out  DWIDTH  fetch read data.
REQ-010 SHALL have port d_req_i  in  1  data request.
REQ-011 SHALL have port d_we_i  in  1  data request is a write.
REQ-012 SHALL have port d_addr_i  in  AWIDTH  data byte address.
REQ-013 SHALL have port d_wdata_i  in  DWIDTH  store data.
REQ-014 SHALL have port d_gnt_o  out  1  data request accepted this cycle.
REQ-015 SHALL have port d_rvalid_o  out  1  data response pulse; also acks writes.
REQ-016 SHALL have port d_rdata_o  out  DWIDTH  load data; zero for write responses.
REQ-017 SHALL have ports mem_addr_o (AWIDTH), mem_data_o (DWIDTH), mem_read_en_o (1), mem_write_en_o (1) out, and mem_data_i (DWIDTH) in, for the shared memory (combinational read, clocked write).

Function
REQ-018 SHALL implement FSM {IDLE, ACCESS}; grants are issued only in IDLE.
REQ-019 SHALL, in IDLE with any request, assert exactly one gnt, latch owner/addr/we/wdata, and go to ACCESS next cycle.
REQ-020 SHALL, in IDLE with no request, stay in IDLE with both gnt low.
REQ-021 SHALL, in ACCESS, drive mem_* from latched values only (requester inputs ignored), assert mem_read_en_o for reads or mem_write_en_o for writes, then return to IDLE.
REQ-022 SHALL register mem_data_i at end of ACCESS and pulse the owner's rvalid for exactly one cycle in the following cycle; latency gnt-to-rvalid = 2 cycles; throughput one access per 2 cycles.
REQ-023 SHALL hold rdata outputs stable until the next response to that requester.
REQ-024 SHALL keep mem_read_en_o, mem_write_en_o low in IDLE; mem_addr_o/mem_data_o hold last latched values.
REQ-025 SHALL, on simultaneous if_req_i and d_req_i, select per REQ-033/REQ-034.
REQ-026 SHALL NOT check address range; out-of-range access passes through and returns whatever memory drives (0xDEADBEEF).
REQ-027 SHALL allow a new grant in the same cycle a previous rvalid pulses.
REQ-028 SHALL treat fetch requests as reads regardless of d_we_i.

Reset
REQ-029 SHALL, on rst at a clock edge, enter IDLE; gnt, rvalid, mem enables = 0; rdata, mem_addr_o, mem_data_o = 0; RR pointer = data-last.
REQ-030 SHALL, on rst during ACCESS, abort with no memory write and no rvalid for that access.
REQ-031 SHALL issue no grant in the cycle rst is high.

Configuration
REQ-032 SHALL use macro MEM_ARB_RR_EN for arbitration policy.
REQ-033 SHALL, without MEM_ARB_RR_EN, use fixed priority: data over fetch.
REQ-034 SHALL, with MEM_ARB_RR_EN, use round-robin: on contention grant the requester not granted last; pointer updates on every grant.

Structure
REQ-035 SHALL place state enum (IDLE, ACCESS) and owner enum (OWN_IF, OWN_D) in package mem_arb_pkg.
REQ-036 SHALL contain one sub-module, mem_arb_pick (combinational two-way selector plus RR pointer), instantiated once.

Verification
REQ-037 Fetch only: if_req_i=1, addr 0x01000000, mem holds 0x00500093 -> if_gnt_o at T, mem_read_en_o at T+1, if_rvalid_o with 0x00500093 at T+2.
REQ-038 Store then load: d_we_i=1, 0x01000010, 0xCAFEF00D; then load same addr -> d_rvalid_o pulses twice (write rdata 0), load returns 0xCAFEF00D.
REQ-039 Contention, fixed priority: both req held 6 cycles -> d_gnt_o every grant, if_gnt_o never; with MEM_ARB_RR_EN -> grants alternate D, IF, D.
REQ-040 Reset in ACCESS of store to 0x01000020 -> no mem_write_en_o, no rvalid, memory unchanged, state IDLE.
REQ-041 OOB fetch at 0x00000000 -> if_rvalid_o with 0xDEADBEEF at T+2.
REQ-042 Back-to-back: rvalid cycle coincides with next gnt; no gnt ever while in ACCESS.
